// File: rtl/tap_tempo_meter_if.sv
// Result bundle of the tap tempo meter: measured tempo, BCD digits, period,
// status strobes and the FSM state for observation.
// bpm_valid is a one-cycle strobe with no ready: the consumer samples the result
// on that cycle or reads the held values at any later time until the next strobe.
interface tap_tempo_meter_if;
  logic [7:0]  bpm;
  logic [3:0]  hex100;
  logic [3:0]  hex10;
  logic [3:0]  hex0;
  logic [31:0] beat_period;
  logic        bpm_valid;
  logic        range_err;
  logic        busy;
  logic        tap_led;
  logic [1:0]  state;

  modport master (
    output bpm, hex100, hex10, hex0, beat_period,
    output bpm_valid, range_err, busy, tap_led, state
  );

  modport slave (
    input bpm, hex100, hex10, hex0, beat_period,
    input bpm_valid, range_err, busy, tap_led, state
  );
endinterface

// File: rtl/tap_tempo_meter.sv
// Tap tempo meter: debounces a tap key, times the interval between presses and
// converts it to BPM by serial restoring division followed by double-dabble BCD.
module tap_tempo_meter #(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int MIN_BPM         = 30,
  parameter int MAX_BPM         = 250
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tap,
  tap_tempo_meter_if.master res
);

  localparam logic [63:0] N64     = 64'(CLK_HZ) * 64'd60;
  localparam logic [31:0] N_DIV   = N64[31:0];
  localparam logic [31:0] P_MIN   = 32'(N64 / 64'(MAX_BPM));
  localparam logic [31:0] P_MAX   = 32'(N64 / 64'(MIN_BPM));
  localparam logic [31:0] P_SAT   = P_MAX + 32'd1;
  localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_TIMING, S_DIVIDE, S_CONVERT} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_sync1, r_sync2, r_db_level, r_db_prev;
  logic [31:0] r_db_cnt;
  logic [31:0] r_cnt;
  logic [31:0] r_num, r_den, r_rem;
  logic [7:0]  r_quo, r_bin;
  logic [11:0] r_bcd;
  logic [4:0]  r_step;
  logic [7:0]  r_bpm;
  logic [3:0]  r_hex100, r_hex10, r_hex0;
  logic [31:0] r_beat_period;
  logic        r_bpm_valid, r_range_err, r_tap_led;

  logic        w_press, w_restart, w_accept, w_err;
  logic [32:0] w_rem_shift;
  logic        w_rem_ge;
  logic [31:0] w_rem_next;
  logic [7:0]  w_quo_next;
  logic [11:0] w_bcd_adj;
  logic [19:0] w_dd_next;

  // The debounced level follows the synchronized tap only after it has held the
  // new value for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_db_level <= 1'b1;
      r_db_prev  <= 1'b1;
      r_db_cnt   <= '0;
    end else begin
      r_sync1   <= tap;
      r_sync2   <= r_sync1;
      r_db_prev <= r_db_level;
      if (r_sync2 == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_db_level <= r_sync2;
        r_db_cnt   <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 32'd1;
      end
    end
  end

  assign w_press = r_db_prev & ~r_db_level;

  always_comb begin
    w_state_next = r_state;
    w_restart    = 1'b0;
    w_accept     = 1'b0;
    w_err        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_press) begin
          w_restart    = 1'b1;
          w_state_next = S_TIMING;
        end
      end
      S_TIMING: begin
        if (w_press) begin
          w_restart = 1'b1;
          if (r_cnt < P_MIN) begin
            w_err = 1'b1;
          end else if (r_cnt <= P_MAX) begin
            w_accept     = 1'b1;
            w_state_next = S_DIVIDE;
          end
        end else if (r_cnt == P_SAT) begin
          w_state_next = S_IDLE;
        end
      end
      S_DIVIDE: begin
        if (r_step == 5'd31) w_state_next = S_CONVERT;
      end
      S_CONVERT: begin
        if (r_step == 5'd7) w_state_next = S_TIMING;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // One restoring-division step; the quotient never exceeds 255, so only its
  // low byte is kept as the bits shift in.
  always_comb begin
    w_rem_shift = {r_rem, r_num[31]};
    w_rem_ge    = (w_rem_shift >= {1'b0, r_den});
    w_rem_next  = w_rem_ge ? 32'(w_rem_shift - {1'b0, r_den}) : w_rem_shift[31:0];
    w_quo_next  = (r_quo << 1) | {7'd0, w_rem_ge};
  end

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int d = 0; d < 3; d++) begin
      if (r_bcd[d*4 +: 4] >= 4'd5) w_bcd_adj[d*4 +: 4] = r_bcd[d*4 +: 4] + 4'd3;
    end
    w_dd_next = {w_bcd_adj, r_bin} << 1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_num         <= '0;
      r_den         <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_bin         <= '0;
      r_bcd         <= '0;
      r_step        <= '0;
      r_bpm         <= '0;
      r_hex100      <= '0;
      r_hex10       <= '0;
      r_hex0        <= '0;
      r_beat_period <= '0;
      r_bpm_valid   <= 1'b0;
      r_range_err   <= 1'b0;
      r_tap_led     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_range_err <= w_err;
      r_bpm_valid <= 1'b0;
      if (w_press) r_tap_led <= ~r_tap_led;
      // Counter holds the number of cycles since the last press, so it reads
      // exactly the interval on the cycle of the next press.
      if (w_restart) r_cnt <= 32'd1;
      else if (r_cnt != P_SAT) r_cnt <= r_cnt + 32'd1;
      if (w_accept) begin
        r_den  <= r_cnt;
        r_num  <= N_DIV;
        r_rem  <= '0;
        r_quo  <= '0;
        r_step <= '0;
      end
      case (r_state)
        S_DIVIDE: begin
          r_num  <= r_num << 1;
          r_rem  <= w_rem_next;
          r_quo  <= w_quo_next;
          r_step <= r_step + 5'd1;
          if (r_step == 5'd31) begin
            r_bin  <= w_quo_next;
            r_bcd  <= '0;
            r_step <= '0;
          end
        end
        S_CONVERT: begin
          r_bcd  <= w_dd_next[19:8];
          r_bin  <= w_dd_next[7:0];
          r_step <= r_step + 5'd1;
          if (r_step == 5'd7) begin
            r_step        <= '0;
            r_bpm         <= r_quo;
            r_hex100      <= w_dd_next[19:16];
            r_hex10       <= w_dd_next[15:12];
            r_hex0        <= w_dd_next[11:8];
            r_beat_period <= r_den;
            r_bpm_valid   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign res.bpm         = r_bpm;
  assign res.hex100      = r_hex100;
  assign res.hex10       = r_hex10;
  assign res.hex0        = r_hex0;
  assign res.beat_period = r_beat_period;
  assign res.bpm_valid   = r_bpm_valid;
  assign res.range_err   = r_range_err;
  assign res.tap_led     = r_tap_led;
  assign res.busy        = (r_state == S_DIVIDE) || (r_state == S_CONVERT);
  assign res.state       = r_state;

endmodule

// File: tb/tb_tap_tempo_meter.sv
// Bench for tap_tempo_meter: scripted tap sequences with a result scoreboard
// fed from a reference BPM/BCD model.
module tb_tap_tempo_meter;
  localparam int CLK_HZ = 1000;
  localparam int HOLD   = 8;
  localparam int W      = 52;

  logic clock;
  logic reset;
  logic tap;

  tap_tempo_meter_if res_if ();

  tap_tempo_meter #(
    .CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(4), .MIN_BPM(30), .MAX_BPM(250)
  ) dut (
    .clock(clock),
    .reset(reset),
    .tap(tap),
    .res(res_if)
  );

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_led = 0;
  int valid_cyc = 0;
  int led_cyc = 0;
  logic prev_led = 1'b0;
  logic prev_valid = 1'b0;

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  function automatic logic [W-1:0] model(input int p);
    int b;
    b = (60 * CLK_HZ) / p;
    return {8'(b), 4'(b / 100), 4'((b / 10) % 10), 4'(b % 10), 32'(p)};
  endfunction

  // scoreboard / monitor
  always @(negedge clock) begin
    logic [W-1:0] got, exp_v;
    if (res_if.tap_led !== prev_led) begin
      n_led++;
      led_cyc = cyc;
    end
    prev_led = res_if.tap_led;
    if (res_if.range_err === 1'b1) n_err++;
    if (res_if.bpm_valid === 1'b1) begin
      n_valid++;
      valid_cyc = cyc;
      n_tests++;
      if (prev_valid === 1'b1) begin
        n_fail++;
        $display("FAIL valid_width: bpm_valid high %0d cycles in a row, required 1", 2);
      end
      got = {res_if.bpm, res_if.hex100, res_if.hex10, res_if.hex0, res_if.beat_period};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got %h, none expected", got);
      end else begin
        exp_v = exp_q.pop_front();
        if (got !== exp_v) begin
          n_fail++;
          $display("FAIL result: got %h required %h", got, exp_v);
        end
      end
    end
    prev_valid = res_if.bpm_valid;
  end

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    tap = 1'b1;
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(2);
  endtask

  task automatic press();
    tap = 1'b0;
    wait_cycles(HOLD);
    tap = 1'b1;
  endtask

  task automatic press_and_wait(input int gap);
    press();
    wait_cycles(gap - HOLD);
  endtask

  task automatic push_exp(input int p);
    exp_q.push_back(model(p));
  endtask

  task automatic check_bpm(input string name, input logic [7:0] b, input logic [3:0] h2,
                           input logic [3:0] h1, input logic [3:0] h0);
    n_tests++;
    if ({res_if.bpm, res_if.hex100, res_if.hex10, res_if.hex0} !== {b, h2, h1, h0}) begin
      n_fail++;
      $display("FAIL %s: bpm=%0d hex=%0d/%0d/%0d required bpm=%0d hex=%0d/%0d/%0d", name,
               res_if.bpm, res_if.hex100, res_if.hex10, res_if.hex0, b, h2, h1, h0);
    end
  endtask

  task automatic test_reset();
    tap = 1'b1;
    reset = 1'b1;
    wait_cycles(3);
    check_bpm("reset_bpm", 8'd0, 4'd0, 4'd0, 4'd0);
    n_tests++;
    if ({res_if.beat_period, res_if.bpm_valid, res_if.range_err, res_if.busy,
         res_if.tap_led, res_if.state} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_status: period=%0d valid=%b err=%b busy=%b led=%b state=%0d required all 0",
               res_if.beat_period, res_if.bpm_valid, res_if.range_err, res_if.busy,
               res_if.tap_led, res_if.state);
    end
    reset = 1'b0;
    wait_cycles(2);
  endtask

  task automatic test_basic();
    int v0;
    apply_reset();
    v0 = n_valid;
    press_and_wait(500);
    n_tests++;
    if (n_valid !== v0) begin
      n_fail++;
      $display("FAIL first_press: %0d results, required 0", n_valid - v0);
    end
    n_tests++;
    if (res_if.state !== 2'd1) begin
      n_fail++;
      $display("FAIL timing_state: state=%0d required 1", res_if.state);
    end
    push_exp(500);
    press_and_wait(400);
    check_bpm("bpm_120", 8'd120, 4'd1, 4'd2, 4'd0);
    n_tests++;
    if (res_if.beat_period !== 32'd500) begin
      n_fail++;
      $display("FAIL period_500: got %0d required 500", res_if.beat_period);
    end
    n_tests++;
    if (valid_cyc - led_cyc !== 40) begin
      n_fail++;
      $display("FAIL latency: result %0d cycles after E+1, required 40", valid_cyc - led_cyc);
    end
    push_exp(400);
    press_and_wait(60);
    check_bpm("bpm_150", 8'd150, 4'd1, 4'd5, 4'd0);
  endtask

  task automatic test_bounce();
    int l0, v0;
    apply_reset();
    l0 = n_led;
    v0 = n_valid;
    tap = 1'b0;
    wait_cycles(3);
    tap = 1'b1;
    wait_cycles(12);
    n_tests++;
    if (n_led !== l0) begin
      n_fail++;
      $display("FAIL short_glitch: %0d toggles, required 0", n_led - l0);
    end
    for (int i = 0; i < 5; i++) begin
      tap = 1'b0;
      wait_cycles(2);
      tap = 1'b1;
      wait_cycles(2);
    end
    tap = 1'b0;
    wait_cycles(20);
    tap = 1'b1;
    wait_cycles(20);
    n_tests++;
    if (n_led !== l0 + 1 || n_valid !== v0) begin
      n_fail++;
      $display("FAIL bounce: %0d toggles %0d results, required 1 and 0", n_led - l0, n_valid - v0);
    end
  endtask

  task automatic test_boundaries();
    int e0;
    apply_reset();
    e0 = n_err;
    press_and_wait(240);
    push_exp(240);
    press_and_wait(2000);
    check_bpm("bpm_250", 8'd250, 4'd2, 4'd5, 4'd0);
    push_exp(2000);
    press_and_wait(239);
    check_bpm("bpm_30", 8'd30, 4'd0, 4'd3, 4'd0);
    press();
    wait_cycles(50);
    n_tests++;
    if (n_err !== e0 + 1) begin
      n_fail++;
      $display("FAIL range_err_239: %0d pulses, required 1", n_err - e0);
    end
    check_bpm("held_after_err", 8'd30, 4'd0, 4'd3, 4'd0);
    wait_cycles(300 - HOLD - 50);
    push_exp(300);
    press_and_wait(60);
    check_bpm("bpm_200", 8'd200, 4'd2, 4'd0, 4'd0);
  endtask

  task automatic test_truncation();
    apply_reset();
    press_and_wait(499);
    push_exp(499);
    press_and_wait(241);
    check_bpm("trunc_499", 8'd120, 4'd1, 4'd2, 4'd0);
    push_exp(241);
    press_and_wait(60);
    check_bpm("trunc_241", 8'd248, 4'd2, 4'd4, 4'd8);
  endtask

  task automatic test_timeout();
    int v0;
    apply_reset();
    press_and_wait(300);
    push_exp(300);
    press_and_wait(2100);
    n_tests++;
    if (res_if.state !== 2'd0) begin
      n_fail++;
      $display("FAIL timeout_state: state=%0d required 0", res_if.state);
    end
    check_bpm("timeout_hold", 8'd200, 4'd2, 4'd0, 4'd0);
    v0 = n_valid;
    press_and_wait(600);
    n_tests++;
    if (n_valid !== v0 || res_if.state !== 2'd1) begin
      n_fail++;
      $display("FAIL restart_press: %0d results state=%0d, required 0 and 1", n_valid - v0, res_if.state);
    end
    check_bpm("restart_hold", 8'd200, 4'd2, 4'd0, 4'd0);
    push_exp(600);
    press_and_wait(60);
    check_bpm("bpm_100", 8'd100, 4'd1, 4'd0, 4'd0);
  endtask

  task automatic test_busy_drop();
    int l0, v0;
    apply_reset();
    press_and_wait(300);
    push_exp(300);
    l0 = n_led;
    v0 = n_valid;
    tap = 1'b0;
    wait_cycles(5);
    tap = 1'b1;
    wait_cycles(5);
    n_tests++;
    if (res_if.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy: got %b required 1", res_if.busy);
    end
    tap = 1'b0;
    wait_cycles(5);
    tap = 1'b1;
    wait_cycles(60);
    n_tests++;
    if (n_led !== l0 + 2 || n_valid !== v0 + 1) begin
      n_fail++;
      $display("FAIL dropped_press: %0d toggles %0d results, required 2 and 1", n_led - l0, n_valid - v0);
    end
    check_bpm("busy_result", 8'd200, 4'd2, 4'd0, 4'd0);
    // The dropped press must not have restarted the interval.
    wait_cycles(225);
    push_exp(300);
    press_and_wait(60);
    n_tests++;
    if (res_if.beat_period !== 32'd300) begin
      n_fail++;
      $display("FAIL no_restart: period=%0d required 300", res_if.beat_period);
    end
  endtask

  task automatic test_reset_mid();
    int v0;
    logic old_led, found;
    apply_reset();
    press_and_wait(300);
    v0 = n_valid;
    old_led = res_if.tap_led;
    found = 1'b0;
    tap = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      wait_cycles(1);
      if (res_if.tap_led !== old_led) found = 1'b1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL press_seen: tap_led=%b required %b", res_if.tap_led, ~old_led);
    end
    tap = 1'b1;
    wait_cycles(19);
    reset = 1'b1;
    wait_cycles(1);
    check_bpm("midreset_bpm", 8'd0, 4'd0, 4'd0, 4'd0);
    n_tests++;
    if ({res_if.beat_period, res_if.bpm_valid, res_if.busy, res_if.tap_led, res_if.state} !== 37'd0) begin
      n_fail++;
      $display("FAIL midreset_status: period=%0d valid=%b busy=%b led=%b state=%0d required all 0",
               res_if.beat_period, res_if.bpm_valid, res_if.busy, res_if.tap_led, res_if.state);
    end
    reset = 1'b0;
    wait_cycles(60);
    n_tests++;
    if (n_valid !== v0 || res_if.bpm !== 8'd0) begin
      n_fail++;
      $display("FAIL abandoned: %0d results bpm=%0d, required 0 and 0", n_valid - v0, res_if.bpm);
    end
  endtask

  initial begin
    reset = 1'b1;
    tap = 1'b1;
    test_reset();
    test_basic();
    test_bounce();
    test_boundaries();
    test_truncation();
    test_timeout();
    test_busy_drop();
    test_reset_mid();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_results: %0d expected results never arrived, required 0", exp_q.size());
    end
    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
